// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Latency: grant in cycle T, resp_valid from T+2; at most one operation in flight.
// Backpressure: a pending response (resp_valid & !resp_ready) holds resp_* and blocks all grants.
//
// Optional feature macro: ALU_ARBITER_STATS_EN adds output stat_ops (count of accepted responses).
//
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is a one-hot grant, IDLE only
//   req_a/req_b/req_op    packed per-requester operands/opcode (slice i)
//   alu_a/alu_b/alu_op    registered operands/opcode to the ALU
//   alu_result/alu_flags  combinational ALU outputs, captured one cycle after the grant
//   resp_valid/resp_ready response handshake
//   resp_id/result/flags  granted requester index, captured result and flags
//   stat_ops              (macro only) accepted-response counter, wraps at 2^32
module alu_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int NREQ     = 4,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef ALU_ARBITER_STATS_EN
  output logic [31:0]              stat_ops,
`endif
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORDSIZE-1:0] req_a,
  input  logic [NREQ*WORDSIZE-1:0] req_b,
  input  logic [NREQ*6-1:0]        req_op,
  output logic [WORDSIZE-1:0]      alu_a,
  output logic [WORDSIZE-1:0]      alu_b,
  output logic [5:0]               alu_op,
  input  logic [WORDSIZE-1:0]      alu_result,
  input  logic [7:0]               alu_flags,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WORDSIZE-1:0]      resp_result,
  output logic [7:0]               resp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;

  // Search from rr_ptr upward, wrapping modulo NREQ; first pending requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant is offered only while idle, so a pending response blocks new work.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            alu_a    <= req_a[gnt_idx*WORDSIZE +: WORDSIZE];
            alu_b    <= req_b[gnt_idx*WORDSIZE +: WORDSIZE];
            alu_op   <= req_op[gnt_idx*6 +: 6];
            grant_id <= gnt_idx;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_flags  <= alu_flags;
          resp_id     <= grant_id;
          resp_valid  <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            // Next search starts just past the requester that was served.
            rr_ptr     <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset)                     stat_ops <= '0;
    else if (resp_valid && resp_ready) stat_ops <= stat_ops + 32'd1;
  end
`endif

endmodule
